adder_result_checker: RTL

Synthesisable, parametrised protocol and result checker for the adder IP, bound alongside the DUT.
- Models the adder's latency with an internal delay line of expected results.
- Compares DUT valid_out/sum/cout every cycle and reports any mismatch.
- Keeps saturating transaction and error counters, sticky error flags and a first-error capture.
- Replaces the static combinational-mode check with a cycle-accurate comparison for every pipeline depth, including 0.

---
 rtl/adder_chk_pkg.sv | 38 +++
 rtl/adder_chk_delay.sv | 46 ++++
 rtl/adder_result_checker.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/adder_chk_pkg.sv
// Shared types and helpers for the adder result checker.
//   chk_state_e    : checker FSM states
//   ERR_IDX_*      : bit positions inside err_flags {x, valid, data}
//   calc_expected  : reference {cout,sum} for an add/sub at up to MAX_W bits
package adder_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } chk_state_e;

  localparam int ERR_IDX_X     = 2;
  localparam int ERR_IDX_VALID = 1;
  localparam int ERR_IDX_DATA  = 0;

  // Widest operand the reference model supports.
  localparam int MAX_W = 64;

  // Returns a MAX_W+1 bit result whose low width+1 bits are {cout,sum}.
  // Operands are masked to 'width' so that ~b does not set bits above the
  // operand, which would otherwise corrupt the carry position.
  function automatic logic [MAX_W:0] calc_expected(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input logic             op_sub,
    input int unsigned      width
  );
    logic [MAX_W:0] mask;
    logic [MAX_W:0] a_eff;
    logic [MAX_W:0] b_eff;
    mask  = ((MAX_W+1)'(1) << width) - (MAX_W+1)'(1);
    a_eff = {1'b0, a} & mask;
    b_eff = op_sub ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
    return a_eff + b_eff + (MAX_W+1)'(op_sub);
  endfunction

endpackage

// File: rtl/adder_chk_delay.sv
// LATENCY-deep shift register of {vld, data} with synchronous reset.
//   clk, rst             : clock, synchronous active-high reset
//   src_vld, src_data    : expectation entering the line
//   dly_vld, dly_data    : expectation LATENCY cycles later
// LATENCY=0 is a combinational pass-through.
module adder_chk_delay #(
  parameter int LATENCY = 1,
  parameter int WIDTH   = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_vld,
  input  logic [WIDTH-1:0] src_data,
  output logic             dly_vld,
  output logic [WIDTH-1:0] dly_data
);

  if (LATENCY == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign dly_vld  = src_vld;
    assign dly_data = src_data;
  end else begin : g_pipe
    logic [LATENCY-1:0]            vld_reg;
    logic [LATENCY-1:0][WIDTH-1:0] data_reg;

    // No stall: every stage advances every cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_reg  <= '0;
        data_reg <= '0;
      end else begin
        vld_reg[0]  <= src_vld;
        data_reg[0] <= src_data;
        for (int i = 1; i < LATENCY; i++) begin
          vld_reg[i]  <= vld_reg[i-1];
          data_reg[i] <= data_reg[i-1];
        end
      end
    end

    assign dly_vld  = vld_reg[LATENCY-1];
    assign dly_data = data_reg[LATENCY-1];
  end

endmodule

// File: rtl/adder_result_checker.sv
// Cycle-accurate protocol/result checker for the adder IP.
//   clk, rst, clear, chk_en       : control (rst > clear > update)
//   valid_in, op_sub, a, b        : DUT inputs, used to build expectations
//   valid_out, sum, cout          : DUT outputs, compared against the delay line
//   err_pulse                     : registered one-cycle pulse per errored cycle
//   err_flags                     : sticky {x_err, valid_err, data_err}
//   txn_cnt, err_cnt              : saturating counters
//   first_vld/first_exp/first_act : capture of the first data error
//   halted                        : FSM in HALT
module adder_result_checker
  import adder_chk_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int LATENCY     = 1,
  parameter int CNT_WIDTH   = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chk_en,
  input  logic                  clear,
  input  logic                  valid_in,
  input  logic                  op_sub,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  valid_out,
  input  logic [DATA_WIDTH-1:0] sum,
  input  logic                  cout,
  output logic                  err_pulse,
  output logic [2:0]            err_flags,
  output logic [CNT_WIDTH-1:0]  txn_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic                  first_vld,
  output logic [DATA_WIDTH:0]   first_exp,
  output logic [DATA_WIDTH:0]   first_act,
  output logic                  halted
);

  localparam int EW = DATA_WIDTH + 1;

  logic [MAX_W:0]   calc_full;
  logic [EW-1:0]    exp_now;
  logic             dly_vld;
  logic [EW-1:0]    dly_exp;
  logic [EW-1:0]    act;
  logic             x_err, valid_err, data_err, any_err, active, txn_hit;
  logic [2:0]       err_now;

  chk_state_e             state_reg, state_next;
  logic                   err_pulse_reg;
  logic [2:0]             err_flags_reg;
  logic [CNT_WIDTH-1:0]   txn_cnt_reg, err_cnt_reg;
  logic                   first_vld_reg;
  logic [EW-1:0]          first_exp_reg, first_act_reg;

  assign calc_full = calc_expected(MAX_W'(a), MAX_W'(b), op_sub, DATA_WIDTH);
  assign exp_now   = calc_full[EW-1:0];

  if (EW < MAX_W + 1) begin : g_unused_hi
    logic unused_calc_hi;
    assign unused_calc_hi = ^calc_full[MAX_W:EW];
  end

  // The line runs regardless of FSM state so expectations are ready the
  // moment checking is enabled.
  adder_chk_delay #(
    .LATENCY (LATENCY),
    .WIDTH   (EW)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .src_vld  (valid_in),
    .src_data (exp_now),
    .dly_vld  (dly_vld),
    .dly_data (dly_exp)
  );

  assign act = {cout, sum};

`ifdef SYNTHESIS
  assign x_err = 1'b0;
`else
  assign x_err = (valid_in  && $isunknown({a, b, op_sub})) ||
                 (valid_out && $isunknown({sum, cout}));
`endif

  assign valid_err = (valid_out != dly_vld);
  assign data_err  = dly_vld && valid_out && (act != dly_exp);
  assign any_err   = x_err || valid_err || data_err;
  assign txn_hit   = dly_vld && valid_out;

  always_comb begin
    err_now = '0;
    err_now[ERR_IDX_X]     = x_err;
    err_now[ERR_IDX_VALID] = valid_err;
    err_now[ERR_IDX_DATA]  = data_err;
  end

  // Compares follow chk_en directly so the cycle chk_en rises is already
  // checked; the state register only records RUN/IDLE/HALT.
  assign active = chk_en && (state_reg != HALT);

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (chk_en) state_next = (STOP_ON_ERR != 0 && any_err) ? HALT : RUN;
      RUN: begin
        if (!chk_en)                           state_next = IDLE;
        else if (STOP_ON_ERR != 0 && any_err)  state_next = HALT;
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = chk_en ? RUN : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      err_pulse_reg <= 1'b0;
      err_flags_reg <= '0;
      txn_cnt_reg   <= '0;
      err_cnt_reg   <= '0;
      first_vld_reg <= 1'b0;
      first_exp_reg <= '0;
      first_act_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (clear) begin
        // Any event in the clear cycle is dropped.
        err_pulse_reg <= 1'b0;
        err_flags_reg <= '0;
        txn_cnt_reg   <= '0;
        err_cnt_reg   <= '0;
        first_vld_reg <= 1'b0;
        first_exp_reg <= '0;
        first_act_reg <= '0;
      end else if (active) begin
        err_pulse_reg <= any_err;
        err_flags_reg <= err_flags_reg | err_now;
        if (any_err && err_cnt_reg != '1)
          err_cnt_reg <= err_cnt_reg + CNT_WIDTH'(1);
        if (txn_hit && txn_cnt_reg != '1)
          txn_cnt_reg <= txn_cnt_reg + CNT_WIDTH'(1);
        if (data_err && !first_vld_reg) begin
          first_vld_reg <= 1'b1;
          first_exp_reg <= dly_exp;
          first_act_reg <= act;
        end
      end else begin
        err_pulse_reg <= 1'b0;
      end
    end
  end

  assign err_pulse = err_pulse_reg;
  assign err_flags = err_flags_reg;
  assign txn_cnt   = txn_cnt_reg;
  assign err_cnt   = err_cnt_reg;
  assign first_vld = first_vld_reg;
  assign first_exp = first_exp_reg;
  assign first_act = first_act_reg;
  assign halted    = (state_reg == HALT);

endmodule
